// File: rtl/row_packer_pkg.sv
// row_packer_pkg: shared defaults and the index-width helper for the row packer slice.
//   DEF_VALUE_BITS / DEF_WIDTH / DEF_CHANNELS : default geometry (8-bit values, 28-pixel rows, 1 channel)
//   clog2(n) : index width for n entries, never narrower than 1 bit
package row_packer_pkg;

    localparam int DEF_VALUE_BITS = 8;
    localparam int DEF_WIDTH      = 28;
    localparam int DEF_CHANNELS   = 1;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/row_packer_if.sv
// row_packer_if: pixel-stream in / row out handshake bundle.
//   in_value_i/in_valid_i/in_last_i -> packer, in_accept_o <- packer   (pixel side)
//   out_row_o/out_row_valid_o/out_row_last_o <- packer, out_row_accept_i -> packer (row side)
//   master: the environment (pixel source + row consumer); slave: the packer.
interface row_packer_if
    import row_packer_pkg::*;
#(
    parameter int VALUE_BITS = DEF_VALUE_BITS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS
);
    logic [CHANNELS-1:0][VALUE_BITS-1:0]            in_value_i;
    logic                                           in_valid_i;
    logic                                           in_accept_o;
    logic                                           in_last_i;
    logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] out_row_o;
    logic                                           out_row_valid_o;
    logic                                           out_row_accept_i;
    logic                                           out_row_last_o;

    modport master (
        output in_value_i, in_valid_i, in_last_i, out_row_accept_i,
        input  in_accept_o, out_row_o, out_row_valid_o, out_row_last_o
    );

    modport slave (
        input  in_value_i, in_valid_i, in_last_i, out_row_accept_i,
        output in_accept_o, out_row_o, out_row_valid_o, out_row_last_o
    );
endinterface

// File: rtl/row_packer_row_buffer.sv
// row_buffer: WIDTH x CHANNELS register bank holding one row.
//   clock_i : rising-edge clock
//   wr_en   : write pix into column col this cycle
//   col     : column index
//   pix     : one pixel, all channels
//   row     : whole row, unmasked
// No reset: contents are only meaningful once the owning flag marks the row full.
module row_buffer #(
    parameter int VALUE_BITS = 8,
    parameter int WIDTH      = 28,
    parameter int CHANNELS   = 1,
    parameter int COL_W      = 5
) (
    input  logic                                           clock_i,
    input  logic                                           wr_en,
    input  logic [COL_W-1:0]                               col,
    input  logic [CHANNELS-1:0][VALUE_BITS-1:0]            pix,
    output logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] row
);
    always_ff @(posedge clock_i) begin
        if (wr_en) row[col] <= pix;
    end
endmodule

// File: rtl/row_packer.sv
// row_packer: packs a pixel stream into full-width rows, ping-pong buffered.
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset; discards any partial row and pending rows
//   bus     : row_packer_if slave (pixel in handshake, row out handshake)
// One buffer fills while the other waits for the consumer; rows leave in fill order.
module row_packer
    import row_packer_pkg::*;
#(
    parameter int VALUE_BITS = DEF_VALUE_BITS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS
) (
    input  logic       clock_i,
    input  logic       reset_i,
    row_packer_if.slave bus
);
    localparam int COL_W = clog2(WIDTH);
    localparam int LEN_W = clog2(WIDTH + 1);

    typedef logic [WIDTH-1:0][CHANNELS-1:0][VALUE_BITS-1:0] row_t;

    logic [COL_W-1:0] col;
    logic             fill_sel, rd_sel;
    logic [1:0]       full, last;
    logic [LEN_W-1:0] len [2];

    logic       take, row_done, drain;
    logic [1:0] wr_en;
    row_t       buf_row [2];
    row_t       out_row;
    row_t       sel_row;
    logic [LEN_W-1:0] rd_len;

    // Accept depends only on registered state (and reset), never on in_valid_i.
    assign bus.in_accept_o = !full[fill_sel] && !reset_i;
    assign take     = bus.in_valid_i && bus.in_accept_o;
    assign row_done = take && (col == COL_W'(WIDTH - 1) || bus.in_last_i);
    assign drain    = full[rd_sel] && bus.out_row_accept_i;
    assign wr_en    = take ? (fill_sel ? 2'b10 : 2'b01) : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        row_buffer #(
            .VALUE_BITS(VALUE_BITS),
            .WIDTH     (WIDTH),
            .CHANNELS  (CHANNELS),
            .COL_W     (COL_W)
        ) u_buf (
            .clock_i(clock_i),
            .wr_en  (wr_en[b]),
            .col    (col),
            .pix    (bus.in_value_i),
            .row    (buf_row[b])
        );
    end

    // A fill can only target an empty buffer and a drain only a full one, so the
    // two updates below never touch the same flag in one cycle.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            col      <= '0;
            fill_sel <= 1'b0;
            rd_sel   <= 1'b0;
            full     <= '0;
            last     <= '0;
        end else begin
            if (take) col <= row_done ? '0 : col + 1'b1;
            if (row_done) begin
                full[fill_sel] <= 1'b1;
                last[fill_sel] <= bus.in_last_i;
                len[fill_sel]  <= LEN_W'(col) + 1'b1;
                fill_sel       <= ~fill_sel;
            end
            if (drain) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

    // Partial rows are masked here rather than cleared in the buffer; stale
    // columns from an earlier row never reach the consumer.
    assign sel_row = buf_row[rd_sel];
    assign rd_len  = len[rd_sel];

    for (genvar c = 0; c < WIDTH; c++) begin : g_mask
        assign out_row[c] = (full[rd_sel] && (LEN_W'(c) < rd_len)) ? sel_row[c] : '0;
    end

    assign bus.out_row_o       = out_row;
    assign bus.out_row_valid_o = full[rd_sel];
    assign bus.out_row_last_o  = last[rd_sel] & full[rd_sel];
endmodule
